io_uart_tx: RTL and testbench

- Downstream output stage for the 8-bit CPU's OUT instructions.
- Accepts one byte per write strobe from the CPU output path and buffers it in a small synchronous FIFO.
- Serialises each byte as a UART 8N1 frame on a single `tx` line.
- Decouples the CPU's single-cycle OUT execution from the slow serial line. The CPU monitors `full` and `overflow` to avoid losing data.

---
 rtl/uart_pkg.sv | 19 +
 rtl/io_uart_tx_if.sv | 24 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/io_uart_tx.sv | 127 ++++++++++++
 tb/tb_io_uart_tx.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    // Serialiser states; the encoding is fixed at 2 bits.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Line levels for the framing bits of an 8N1 frame.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Default baud divider when the instantiating level does not override it.
    localparam int CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/io_uart_tx_if.sv
// CPU-facing write port and FIFO status of the UART transmitter.
interface io_uart_tx_if #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 8
);
    logic                          wr_en;
    logic [DW-1:0]                 wr_data;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   level;
    logic                          overflow;

    // CPU side: drives writes, watches the status flags.
    modport master (
        output wr_en, wr_data,
        input  full, empty, level, overflow
    );

    // Transmitter side: consumes writes, reports the status flags.
    modport slave (
        input  wr_en, wr_data,
        output full, empty, level, overflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter and sticky overflow flag.
// A write while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DW-1:0]           din,
    input  logic                    pop,
    output logic [DW-1:0]           dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and overflow; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level <= level + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level <= level - 1'b1;
            end
            if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// UART 8N1 transmitter fed by a byte FIFO from the CPU OUT path.
// tx is registered from the next-state decode so the start bit appears
// on the same edge that pops the byte.
module io_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 8,
    parameter int DW           = 8
) (
    input  logic       clk,
    input  logic       rst,
    io_uart_tx_if.slave bus,
    output logic       busy,
    output logic       tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    uart_state_t   state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [DW-1:0] shift;
    logic [DW-1:0] shift_next;
    logic [DW-1:0] fifo_dout;
    logic          pop;
    logic          bit_done;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.wr_en),
        .din      (bus.wr_data),
        .pop      (pop),
        .dout     (fifo_dout),
        .full     (bus.full),
        .empty    (bus.empty),
        .level    (bus.level),
        .overflow (bus.overflow)
    );

    assign bit_done = (cnt == CNT_MAX);
    assign busy     = (state != IDLE);

    // Next-state, baud counter, bit index, shift register and FIFO pop.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_dout;
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    shift_next = shift >> 1;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control registers: state, baud counter, bit index and the tx line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            tx    <= STOP_BIT;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            case (state_next)
                START:   tx <= START_BIT;
                DATA:    tx <= shift_next[0];
                default: tx <= STOP_BIT;
            endcase
        end
    end

    // Data shift register, left without reset.
    always_ff @(posedge clk) begin
        shift <= shift_next;
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: a line receiver decodes tx and
// checks each frame against a queue of expected bytes.
module tb_io_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    logic busy;
    logic tx;

    int vectors;
    int miscompares;
    int rx_count;

    logic [7:0] sb[$];

    io_uart_tx_if #(.DW(8), .FIFO_DEPTH(DEPTH)) bus ();

    io_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DW           (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy),
        .tx   (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line receiver: samples each bit at its centre and scores the byte.
    bit         rx_active;
    int         rx_cnt;
    logic [7:0] rx_byte;
    logic [7:0] rx_exp;
    initial begin
        rx_active = 1'b0;
        rx_cnt    = 0;
        rx_byte   = '0;
        rx_count  = 0;
    end
    always @(negedge clk) begin
        if (rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 2) begin
                vectors++;
                if (tx !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rx_start_bit: got %b want 0 at %0t", tx, $time);
                end
            end else if (rx_cnt % CPB == 2 && rx_cnt < 9 * CPB) begin
                rx_byte = {tx, rx_byte[7:1]};
            end else if (rx_cnt == 9 * CPB + 2) begin
                rx_active = 1'b0;
                rx_count++;
                vectors++;
                if (tx !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rx_stop_bit: got %b want 1 at %0t", tx, $time);
                end
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rx_unexpected: got %02h want no frame at %0t", rx_byte, $time);
                end else begin
                    rx_exp = sb.pop_front();
                    if (rx_byte !== rx_exp) begin
                        miscompares++;
                        $display("FAIL rx_byte: got %02h want %02h at %0t", rx_byte, rx_exp, $time);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d pending busy=%b want 0 pending busy=0", name, sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        @(posedge clk);
        #1;
        vectors += 6;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", bus.full); end
        if (bus.level !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        do_reset();
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5;
        sb.push_back(8'hA5);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.wr_data = 'x;
        vectors += 2;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL single_pre_tx: got %b want 1", tx); end
        if (bus.level !== 4'd1) begin miscompares++; $display("FAIL single_level: got %0d want 1", bus.level); end
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            vectors += 2;
            if (tx !== frame[i / CPB]) begin
                miscompares++;
                $display("FAIL single_tx[%0d]: got %b want %b", i, tx, frame[i / CPB]);
            end
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL single_busy[%0d]: got %b want 1", i, busy);
            end
        end
        @(negedge clk);
        vectors += 4;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL single_end_busy: got %b want 0", busy); end
        if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL single_end_empty: got %b want 1", bus.empty); end
        if (tx !== 1'b1) begin miscompares++; $display("FAIL single_end_tx: got %b want 1", tx); end
        if (sb.size() != 0) begin miscompares++; $display("FAIL single_rx: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_fill();
        do_reset();
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hEE;
        sb.push_back(8'hEE);
        @(negedge clk);
        bus.wr_en = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) begin
                vectors += 3;
                if (bus.level !== 4'd8) begin miscompares++; $display("FAIL fill_level_peak: got %0d want 8", bus.level); end
                if (bus.full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", bus.full); end
                if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL fill_early_overflow: got %b want 0", bus.overflow); end
            end
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(k);
            if (k <= 8) sb.push_back(8'(k));
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        vectors += 2;
        if (bus.level !== 4'd8) begin miscompares++; $display("FAIL fill_level_after_drop: got %0d want 8", bus.level); end
        if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL fill_overflow: got %b want 1", bus.overflow); end
        wait_drain(12 * (10 * CPB + 1) + 20, "fill");
        vectors++;
        if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL fill_overflow_sticky: got %b want 1", bus.overflow); end
    endtask

    task automatic test_back_to_back();
        logic exp;
        int   j;
        do_reset();
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h00;
        sb.push_back(8'h00);
        @(negedge clk);
        bus.wr_data = 8'hFF;
        sb.push_back(8'hFF);
        @(negedge clk);
        bus.wr_en = 1'b0;
        for (int i = 0; i < 20 * CPB + 1; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 10 * CPB) begin
                exp = (i < 9 * CPB) ? 1'b0 : 1'b1;
            end else if (i == 10 * CPB) begin
                exp = 1'b1;
            end else begin
                j = i - (10 * CPB + 1);
                exp = (j < CPB) ? 1'b0 : 1'b1;
            end
            vectors++;
            if (tx !== exp) begin
                miscompares++;
                $display("FAIL b2b_tx[%0d]: got %b want %b", i, tx, exp);
            end
        end
        wait_drain(CPB * 4, "b2b");
    endtask

    task automatic test_simul();
        do_reset();
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h3C;
        sb.push_back(8'h3C);
        @(negedge clk);
        vectors += 2;
        if (bus.level !== 4'd1) begin miscompares++; $display("FAIL simul_level_before: got %0d want 1", bus.level); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL simul_idle_before: got %b want 0", busy); end
        bus.wr_data = 8'hC3;
        sb.push_back(8'hC3);
        @(negedge clk);
        bus.wr_en = 1'b0;
        vectors += 4;
        if (bus.level !== 4'd1) begin miscompares++; $display("FAIL simul_level: got %0d want 1", bus.level); end
        if (bus.empty !== 1'b0) begin miscompares++; $display("FAIL simul_empty: got %b want 0", bus.empty); end
        if (bus.full !== 1'b0) begin miscompares++; $display("FAIL simul_full: got %b want 0", bus.full); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL simul_busy: got %b want 1", busy); end
        wait_drain(3 * (10 * CPB + 1), "simul");
    endtask

    task automatic test_reset_mid();
        int lows;
        int busys;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.wr_en = 1'b1;
            bus.wr_data = 8'h11 * 8'(k + 1);
            sb.push_back(8'h11 * 8'(k + 1));
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        // first frame started after the first write edge plus one; land in data bit 3
        repeat (CPB * 4 - 1) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        vectors += 5;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx: got %b want 1", tx); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (bus.level !== 4'd0) begin miscompares++; $display("FAIL rstmid_level: got %0d want 0", bus.level); end
        if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL rstmid_empty: got %b want 1", bus.empty); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL rstmid_overflow: got %b want 0", bus.overflow); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        busys = 0;
        for (int i = 0; i < 30 * CPB; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        vectors += 2;
        if (lows != 0) begin miscompares++; $display("FAIL rstmid_quiet_tx: got %0d low cycles want 0", lows); end
        if (busys != 0) begin miscompares++; $display("FAIL rstmid_quiet_busy: got %0d busy cycles want 0", busys); end
    endtask

    task automatic test_wrap();
        int start_count;
        do_reset();
        start_count = rx_count;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.wr_en = 1'b1;
            bus.wr_data = 8'h10 + 8'(k);
            sb.push_back(8'h10 + 8'(k));
            @(negedge clk);
            bus.wr_en = 1'b0;
            bus.wr_data = 'x;
            repeat (10 * CPB + 2) @(negedge clk);
        end
        wait_drain(2 * (10 * CPB + 1), "wrap");
        vectors++;
        if (rx_count - start_count != 20) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d frames want 20", rx_count - start_count);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_simul();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
